branch_resolve_queue: RTL and testbench
=======================================

// Module: branch_resolve_queue
// PURPOSE
//  Sits downstream of the 2-bit saturating-counter predictor. Holds each issued
//  prediction in an in-order FIFO until the branch resolves, then:
//  - compares the prediction against the actual outcome,
//  - flags a mispredict,
//  - drives the predictor's update pair (branch, taken) one cycle later,
//  - keeps saturating statistics counters.
// PARAMETERS
//  DEPTH  4   queue entries; power of 2, >=2
//  CNT_W  16  width of statistics counters
// PORTS
//  clk           in   1      single clock, rising edge
//  reset         in   1      asynchronous, active-high; clears all state
//  pred_valid    in   1      push request: a prediction was issued this cycle
//  pred_taken    in   1      predicted direction (predictor's prediction output)
//  pred_ready    out  1      queue not full (combinational from count)
//  res_valid     in   1      oldest outstanding branch resolved this cycle
//  res_taken     in   1      actual direction of that branch
//  flush         in   1      synchronous: discard all queued entries
//  upd_branch    out  1      registered; feeds the predictor's branch input
//  upd_taken     out  1      registered; feeds the predictor's taken input
//  mispredict    out  1      registered 1-cycle pulse: popped pred_taken != res_taken
//  count         out  log2(DEPTH)+1  current occupancy
//  total_cnt     out  CNT_W  resolved branches; saturates at all-ones
//  miss_cnt      out  CNT_W  mispredicts; saturates at all-ones
//  overflow      out  1      sticky: push attempted while full
//  underflow     out  1      sticky: resolve attempted while empty
// BEHAVIOUR
//  Reset (async assert, any cycle, mid-operation included) clears:
//   - rd/wr pointers and count, so count=0 and pred_ready=1;
//   - upd_branch, upd_taken, mispredict, total_cnt, miss_cnt, overflow, underflow.
//  Push (pred_valid & pred_ready): store pred_taken at wr_ptr; wr_ptr+1 mod DEPTH.
//  Pop (res_valid & count!=0):
//   - read the entry at rd_ptr; rd_ptr+1 mod DEPTH;
//   - next cycle: upd_branch=1, upd_taken=res_taken, mispredict=(entry!=res_taken);
//   - total_cnt+1, and miss_cnt+1 on mismatch; each holds at 2^CNT_W-1.
//  Latency: resolve -> upd_*/mispredict exactly 1 cycle. In any cycle with no pop
//   they read 0 (pulses, never held).
//  Full, push without pop: push dropped, overflow<=1, no state change.
//  Full, push + pop same cycle: both happen; count unchanged. pred_ready still
//   reads 0 that cycle (depends on count only), but the push is accepted.
//  Empty, resolve: no pop, no update pulse, underflow<=1. No bypass: a push in the
//   same cycle is enqueued normally and the resolve is still an underflow.
//  Pointers wrap modulo DEPTH; count is the sole full/empty source (0..DEPTH).
//  flush (sync, over push/pop):
//   - pointers and count -> 0;
//   - same-cycle push and resolve ignored;
//   - stats and sticky flags kept; upd_* = 0 next cycle.
//  Sticky flags clear only on reset.
// TESTING
//  1 Reset, push T,N,T; resolve T,T,N -> upd_branch 1 for 3 cycles, upd_taken 1,1,0;
//    mispredict 0,1,1; total_cnt=3, miss_cnt=2, count ends 0.
//  2 Push 4 (DEPTH=4) -> pred_ready=0, count=4; 5th push -> overflow=1, count=4.
//    Then push+resolve same cycle -> count stays 4, FIFO order preserved.
//  3 Resolve on empty queue (also with same-cycle push) -> underflow=1, no upd pulse;
//    the pushed entry is present, count=1.
//  4 Push 3, flush with same-cycle resolve -> count=0, no upd pulse, total_cnt
//    unchanged.
//  5 Force total_cnt=miss_cnt=2^CNT_W-2 (CNT_W=4 build), 3 mispredicting
//    resolves -> both hold at 15.
//  6 Assert reset asynchronously between edges with count=2 -> all outputs 0
//    immediately, pred_ready=1.

Source files
------------

// File: rtl/branch_resolve_queue_if.sv
// Bundles the prediction push, resolve and predictor-update signals of the branch resolve queue.
// Pure wiring: it holds no state and adds no latency.
// The master side drives pushes and resolves; the slave side (the queue) returns ready, updates and statistics.
interface branch_resolve_queue_if #(
    parameter int DEPTH = 4,
    parameter int CNT_W = 16
);
    localparam int CW = $clog2(DEPTH) + 1;

    logic             pred_valid;
    logic             pred_taken;
    logic             pred_ready;
    logic             res_valid;
    logic             res_taken;
    logic             flush;
    logic             upd_branch;
    logic             upd_taken;
    logic             mispredict;
    logic [CW-1:0]    count;
    logic [CNT_W-1:0] total_cnt;
    logic [CNT_W-1:0] miss_cnt;
    logic             overflow;
    logic             underflow;

    modport master (
        output pred_valid, pred_taken, res_valid, res_taken, flush,
        input  pred_ready, upd_branch, upd_taken, mispredict, count,
               total_cnt, miss_cnt, overflow, underflow
    );

    modport slave (
        input  pred_valid, pred_taken, res_valid, res_taken, flush,
        output pred_ready, upd_branch, upd_taken, mispredict, count,
               total_cnt, miss_cnt, overflow, underflow
    );
endinterface

// File: rtl/branch_resolve_queue.sv
// In-order queue of issued branch predictions, checked against actual outcomes as each branch resolves.
// Latency: a resolve produces the upd_branch/upd_taken/mispredict pulse exactly 1 cycle later.
// Backpressure: pred_ready drops when full; a push while full is accepted only if a pop happens in the same cycle.
module branch_resolve_queue #(
    parameter int DEPTH = 4,
    parameter int CNT_W = 16
) (
    input  logic                  clk,
    input  logic                  reset,
    branch_resolve_queue_if.slave bus
);
    localparam int AW = $clog2(DEPTH);
    localparam int CW = AW + 1;

    logic [DEPTH-1:0] r_mem;
    logic [AW-1:0]    r_wr_ptr;
    logic [AW-1:0]    r_rd_ptr;
    logic [CW-1:0]    r_count;
    logic             r_upd_branch;
    logic             r_upd_taken;
    logic             r_mispredict;
    logic [CNT_W-1:0] r_total_cnt;
    logic [CNT_W-1:0] r_miss_cnt;
    logic             r_overflow;
    logic             r_underflow;

    logic w_full;
    logic w_empty;
    logic w_pop;
    logic w_push;
    logic w_entry;
    logic w_miss;

    // Occupancy is the only source of full/empty.  Flush overrides any push or pop
    // in the same cycle.  A push while full is accepted only when a pop frees the slot.
    always_comb begin
        w_full  = (r_count == CW'(DEPTH));
        w_empty = (r_count == '0);
        w_pop   = bus.res_valid & ~w_empty & ~bus.flush;
        w_push  = bus.pred_valid & (~w_full | w_pop) & ~bus.flush;
        w_entry = r_mem[r_rd_ptr];
        w_miss  = w_entry ^ bus.res_taken;
    end

    // Prediction storage; entries are only read while valid, so they need no reset.
    always_ff @(posedge clk) begin
        if (w_push) begin
            r_mem[r_wr_ptr] <= bus.pred_taken;
        end
    end

    // Pointers and occupancy.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
        end else if (bus.flush) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
        end else begin
            if (w_push) r_wr_ptr <= r_wr_ptr + AW'(1);
            if (w_pop)  r_rd_ptr <= r_rd_ptr + AW'(1);
            unique case ({w_push, w_pop})
                2'b10:   r_count <= r_count + CW'(1);
                2'b01:   r_count <= r_count - CW'(1);
                default: r_count <= r_count;
            endcase
        end
    end

    // Predictor update and mispredict pulses: high only for the cycle after a pop.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_upd_branch <= 1'b0;
            r_upd_taken  <= 1'b0;
            r_mispredict <= 1'b0;
        end else begin
            r_upd_branch <= w_pop;
            r_upd_taken  <= w_pop & bus.res_taken;
            r_mispredict <= w_pop & w_miss;
        end
    end

    // Saturating statistics and sticky error flags; flush leaves them untouched.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_total_cnt <= '0;
            r_miss_cnt  <= '0;
            r_overflow  <= 1'b0;
            r_underflow <= 1'b0;
        end else begin
            if (w_pop && (r_total_cnt != '1)) r_total_cnt <= r_total_cnt + CNT_W'(1);
            if (w_pop && w_miss && (r_miss_cnt != '1)) r_miss_cnt <= r_miss_cnt + CNT_W'(1);
            if (bus.pred_valid && w_full && !w_pop && !bus.flush) r_overflow <= 1'b1;
            if (bus.res_valid && w_empty && !bus.flush) r_underflow <= 1'b1;
        end
    end

    assign bus.pred_ready = ~w_full;
    assign bus.count      = r_count;
    assign bus.upd_branch = r_upd_branch;
    assign bus.upd_taken  = r_upd_taken;
    assign bus.mispredict = r_mispredict;
    assign bus.total_cnt  = r_total_cnt;
    assign bus.miss_cnt   = r_miss_cnt;
    assign bus.overflow   = r_overflow;
    assign bus.underflow  = r_underflow;
endmodule

// File: tb/tb_branch_resolve_queue.sv
// Directed bench for branch_resolve_queue: a DEPTH=4/CNT_W=16 instance plus a CNT_W=4 instance for saturation.
// Inputs change 1 ns after each rising edge; outputs are sampled at that same point.
// No backpressure is modelled beyond the queue's own pred_ready.
module tb_branch_resolve_queue;
    logic clk;
    logic reset;
    int   errors;
    int   checks;

    branch_resolve_queue_if #(.DEPTH(4), .CNT_W(16)) bus0 ();
    branch_resolve_queue_if #(.DEPTH(4), .CNT_W(4))  bus1 ();

    branch_resolve_queue #(.DEPTH(4), .CNT_W(16)) u_dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus0.slave)
    );

    branch_resolve_queue #(.DEPTH(4), .CNT_W(4)) u_dut_sat (
        .clk   (clk),
        .reset (reset),
        .bus   (bus1.slave)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp)
        else begin
            errors++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic drive0(input logic pv, input logic pt, input logic rv, input logic rt, input logic fl);
        bus0.pred_valid = pv;
        bus0.pred_taken = pt;
        bus0.res_valid  = rv;
        bus0.res_taken  = rt;
        bus0.flush      = fl;
    endtask

    task automatic drive1(input logic pv, input logic pt, input logic rv, input logic rt);
        bus1.pred_valid = pv;
        bus1.pred_taken = pt;
        bus1.res_valid  = rv;
        bus1.res_taken  = rt;
        bus1.flush      = 1'b0;
    endtask

    initial begin
        errors = 0;
        checks = 0;
        reset  = 1'b1;
        drive0(0, 0, 0, 0, 0);
        drive1(0, 0, 0, 0);
        #12;

        // Reset state
        chk("rst_count", 32'(bus0.count), 0);
        chk("rst_ready", 32'(bus0.pred_ready), 1);
        chk("rst_upd_branch", 32'(bus0.upd_branch), 0);
        chk("rst_mispredict", 32'(bus0.mispredict), 0);
        chk("rst_total", 32'(bus0.total_cnt), 0);
        chk("rst_overflow", 32'(bus0.overflow), 0);
        chk("rst_underflow", 32'(bus0.underflow), 0);
        reset = 1'b0;

        // 1: push T,N,T then resolve T,T,N
        drive0(1, 1, 0, 0, 0); tick();
        chk("t1_count1", 32'(bus0.count), 1);
        drive0(1, 0, 0, 0, 0); tick();
        drive0(1, 1, 0, 0, 0); tick();
        chk("t1_count3", 32'(bus0.count), 3);
        drive0(0, 0, 1, 1, 0); tick();
        chk("t1_ub0", 32'(bus0.upd_branch), 1);
        chk("t1_ut0", 32'(bus0.upd_taken), 1);
        chk("t1_mp0", 32'(bus0.mispredict), 0);
        drive0(0, 0, 1, 1, 0); tick();
        chk("t1_ub1", 32'(bus0.upd_branch), 1);
        chk("t1_ut1", 32'(bus0.upd_taken), 1);
        chk("t1_mp1", 32'(bus0.mispredict), 1);
        drive0(0, 0, 1, 0, 0); tick();
        chk("t1_ub2", 32'(bus0.upd_branch), 1);
        chk("t1_ut2", 32'(bus0.upd_taken), 0);
        chk("t1_mp2", 32'(bus0.mispredict), 1);
        drive0(0, 0, 0, 0, 0); tick();
        chk("t1_ub_idle", 32'(bus0.upd_branch), 0);
        chk("t1_mp_idle", 32'(bus0.mispredict), 0);
        chk("t1_total", 32'(bus0.total_cnt), 3);
        chk("t1_miss", 32'(bus0.miss_cnt), 2);
        chk("t1_count0", 32'(bus0.count), 0);

        // 2: fill with T,T,N,N, overflow push, then push+pop while full
        drive0(1, 1, 0, 0, 0); tick();
        drive0(1, 1, 0, 0, 0); tick();
        drive0(1, 0, 0, 0, 0); tick();
        drive0(1, 0, 0, 0, 0); tick();
        chk("t2_count_full", 32'(bus0.count), 4);
        chk("t2_ready_full", 32'(bus0.pred_ready), 0);
        chk("t2_ovf_before", 32'(bus0.overflow), 0);
        drive0(1, 0, 0, 0, 0); tick();
        chk("t2_ovf", 32'(bus0.overflow), 1);
        chk("t2_count_ovf", 32'(bus0.count), 4);
        drive0(1, 1, 1, 1, 0); tick();
        chk("t2_count_pp", 32'(bus0.count), 4);
        chk("t2_mp_pp", 32'(bus0.mispredict), 0);
        chk("t2_ub_pp", 32'(bus0.upd_branch), 1);
        // queue now holds T,N,N,T; resolve all taken
        drive0(0, 0, 1, 1, 0); tick();
        chk("t2_mp_d0", 32'(bus0.mispredict), 0);
        tick();
        chk("t2_mp_d1", 32'(bus0.mispredict), 1);
        tick();
        chk("t2_mp_d2", 32'(bus0.mispredict), 1);
        tick();
        chk("t2_mp_d3", 32'(bus0.mispredict), 0);
        chk("t2_ut_d3", 32'(bus0.upd_taken), 1);
        drive0(0, 0, 0, 0, 0); tick();
        chk("t2_count0", 32'(bus0.count), 0);
        chk("t2_total", 32'(bus0.total_cnt), 8);
        chk("t2_miss", 32'(bus0.miss_cnt), 4);

        // 3: resolve on empty with a same-cycle push of N
        chk("t3_udf_before", 32'(bus0.underflow), 0);
        drive0(1, 0, 1, 0, 0); tick();
        chk("t3_udf", 32'(bus0.underflow), 1);
        chk("t3_ub", 32'(bus0.upd_branch), 0);
        chk("t3_count", 32'(bus0.count), 1);
        chk("t3_total", 32'(bus0.total_cnt), 8);
        drive0(0, 0, 1, 1, 0); tick();
        chk("t3_mp_pushed", 32'(bus0.mispredict), 1);
        chk("t3_ut_pushed", 32'(bus0.upd_taken), 1);
        chk("t3_count0", 32'(bus0.count), 0);

        // 4: push 3, flush with same-cycle push and resolve
        drive0(1, 1, 0, 0, 0); tick();
        tick();
        tick();
        chk("t4_count3", 32'(bus0.count), 3);
        drive0(1, 1, 1, 0, 1); tick();
        chk("t4_count_fl", 32'(bus0.count), 0);
        chk("t4_ub_fl", 32'(bus0.upd_branch), 0);
        chk("t4_mp_fl", 32'(bus0.mispredict), 0);
        chk("t4_total", 32'(bus0.total_cnt), 9);
        chk("t4_ovf_kept", 32'(bus0.overflow), 1);
        chk("t4_udf_kept", 32'(bus0.underflow), 1);
        drive0(1, 0, 0, 0, 0); tick();
        drive0(0, 0, 1, 1, 0); tick();
        chk("t4_mp_after", 32'(bus0.mispredict), 1);
        chk("t4_total_after", 32'(bus0.total_cnt), 10);
        chk("t4_miss_after", 32'(bus0.miss_cnt), 6);
        drive0(0, 0, 0, 0, 0);

        // 5: CNT_W=4 saturation; every pop mispredicts (pushed T, resolved N)
        drive1(1, 1, 0, 0); tick();
        drive1(1, 1, 1, 0);
        for (int i = 0; i < 14; i++) tick();
        chk("t5_total14", 32'(bus1.total_cnt), 14);
        chk("t5_miss14", 32'(bus1.miss_cnt), 14);
        for (int i = 0; i < 3; i++) begin
            tick();
            chk($sformatf("t5_total_sat%0d", i), 32'(bus1.total_cnt), 15);
            chk($sformatf("t5_miss_sat%0d", i), 32'(bus1.miss_cnt), 15);
        end
        chk("t5_mp_sat", 32'(bus1.mispredict), 1);
        chk("t5_count", 32'(bus1.count), 1);
        drive1(0, 0, 0, 0);

        // 6: asynchronous reset between edges with count=2 and a pulse live
        drive0(1, 1, 0, 0, 0); tick();
        tick();
        tick();
        drive0(0, 0, 1, 1, 0); tick();
        chk("t6_count2", 32'(bus0.count), 2);
        chk("t6_ub_live", 32'(bus0.upd_branch), 1);
        drive0(0, 0, 0, 0, 0);
        #2;
        reset = 1'b1;
        #1;
        chk("t6_count", 32'(bus0.count), 0);
        chk("t6_ready", 32'(bus0.pred_ready), 1);
        chk("t6_ub", 32'(bus0.upd_branch), 0);
        chk("t6_ut", 32'(bus0.upd_taken), 0);
        chk("t6_total", 32'(bus0.total_cnt), 0);
        chk("t6_miss", 32'(bus0.miss_cnt), 0);
        chk("t6_ovf", 32'(bus0.overflow), 0);
        chk("t6_udf", 32'(bus0.underflow), 0);
        chk("t6_sat_total", 32'(bus1.total_cnt), 0);
        chk("t6_sat_mp", 32'(bus1.mispredict), 0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
